pattern_player: RTL

Parametrised serial pattern generator: it plays a latched bit pattern LSB-first on a single output, holding each bit for a programmable number of clock cycles. It adds a start/busy/done handshake, a variable pattern length, abort, and an optional repeat mode with an inter-repeat gap. It sits between a pattern source (select-driven lookup or CPU register) and an LED/buzzer output, and replaces the fixed 12-bit, fixed-rate shifter.

---
 rtl/pattern_player.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pattern_player.sv
// pattern_player: plays a latched bit pattern LSB-first on `out`, holding each
// bit for RATE_DIV+1 clocks, with start/busy/done handshake and abort.
// Optional repeat mode (GAP state, gap counter, reload copy) is built only when
// PATTERN_PLAYER_REPEAT_EN is defined.
// The repeat request port is named repeat_i because `repeat` is a reserved word.
module pattern_player #(
   parameter int PAT_W     = 12,
   parameter int LEN_W     = $clog2(PAT_W + 1),
   parameter int RATE_W    = 28,
   parameter int RATE_DIV  = 24999999,
   parameter int GAP_TICKS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [PAT_W-1:0] pat_data,
   input  logic [LEN_W-1:0] pat_len,
   input  logic             repeat_i,
   output logic             out,
   output logic             busy,
   output logic             done
);

`ifdef PATTERN_PLAYER_REPEAT_EN
   localparam int GAP_W = $clog2(GAP_TICKS + 1);
   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
`else
   typedef enum logic [1:0] {IDLE, PLAY} state_t;
`endif

   state_t            state_q;
   logic [PAT_W-1:0]  shreg_q;
   logic [LEN_W-1:0]  bits_left_q;
   logic [RATE_W-1:0] rate_q, rate_d;
   logic              done_q;
   logic [LEN_W-1:0]  len_clamped;
   logic              tick;

`ifdef PATTERN_PLAYER_REPEAT_EN
   logic [PAT_W-1:0]  reload_q;
   logic [LEN_W-1:0]  len_q;
   logic              rpt_q;
   logic [GAP_W-1:0]  gap_left_q;
`else
   logic              unused_cfg;
   assign unused_cfg = repeat_i ^ (GAP_TICKS != 0);
`endif

   // Clamp the requested length and decode the bit-period tick.
   always_comb begin
      len_clamped = (pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
      tick        = (state_q != IDLE) && (rate_q == RATE_W'(RATE_DIV));
   end

   // Next rate count: held at zero while idle or aborting, wraps on tick.
   always_comb begin
      rate_d = rate_q + RATE_W'(1);
      if (abort || state_q == IDLE || tick) rate_d = '0;
   end

   // Rate counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rate_q <= '0;
      else       rate_q <= rate_d;
   end

   // Playback FSM with shift register, bit/gap counters and done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         bits_left_q <= '0;
         done_q      <= 1'b0;
`ifdef PATTERN_PLAYER_REPEAT_EN
         reload_q    <= '0;
         len_q       <= '0;
         rpt_q       <= 1'b0;
         gap_left_q  <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         if (abort) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     shreg_q     <= pat_data;
                     bits_left_q <= len_clamped;
`ifdef PATTERN_PLAYER_REPEAT_EN
                     reload_q    <= pat_data;
                     len_q       <= len_clamped;
                     rpt_q       <= repeat_i;
`endif
                     if (len_clamped == '0) done_q  <= 1'b1;
                     else                   state_q <= PLAY;
                  end
               end
               PLAY: begin
                  if (tick) begin
                     shreg_q     <= shreg_q >> 1;
                     bits_left_q <= bits_left_q - LEN_W'(1);
                     if (bits_left_q == LEN_W'(1)) begin
`ifdef PATTERN_PLAYER_REPEAT_EN
                        if (rpt_q) begin
                           state_q    <= GAP;
                           gap_left_q <= GAP_W'(GAP_TICKS);
                        end else begin
                           state_q <= IDLE;
                           done_q  <= 1'b1;
                        end
`else
                        state_q <= IDLE;
                        done_q  <= 1'b1;
`endif
                     end
                  end
               end
`ifdef PATTERN_PLAYER_REPEAT_EN
               GAP: begin
                  if (tick) begin
                     gap_left_q <= gap_left_q - GAP_W'(1);
                     if (gap_left_q == GAP_W'(1)) begin
                        shreg_q     <= reload_q;
                        bits_left_q <= len_q;
                        state_q     <= PLAY;
                     end
                  end
               end
`endif
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // Outputs decoded only from registers.
   always_comb begin
      out  = (state_q == PLAY) && shreg_q[0];
      busy = (state_q != IDLE);
      done = done_q;
   end

endmodule
